// File: rtl/bip_core_mc_if.sv
// Program/data memory bus of the multicycle BIP core.
// master = core side, slave = memory / environment side.
interface bip_core_mc_if #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16
);
  logic [NBITS_D-1:0] i_Instruction;
  logic [NBITS_D-1:0] i_OutData;
  logic               i_DmReady;
  logic [NBITS_O-1:0] o_PmAddr;
  logic [NBITS_O-1:0] o_DmAddr;
  logic               o_Rd;
  logic               o_Wr;
  logic [NBITS_D-1:0] o_InData;
  logic               o_Halted;
  logic               o_IllegalOp;

  modport master (
    input  i_Instruction, i_OutData, i_DmReady,
    output o_PmAddr, o_DmAddr, o_Rd, o_Wr, o_InData, o_Halted, o_IllegalOp
  );

  modport slave (
    output i_Instruction, i_OutData, i_DmReady,
    input  o_PmAddr, o_DmAddr, o_Rd, o_Wr, o_InData, o_Halted, o_IllegalOp
  );
endinterface

// File: rtl/bip_core_mc.sv
// Multicycle accumulator CPU: FETCH -> EXEC -> (MEM) with a data-memory
// wait-state handshake, branches, a halt state and an illegal-opcode pulse.
module bip_core_mc #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5
) (
  input logic           i_clock,
  input logic           i_reset,
  bip_core_mc_if.master bus
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM,
    HALT
  } state_t;

  typedef enum logic [OPCODE-1:0] {
    OP_HLT  = 'h00,
    OP_STO  = 'h01,
    OP_LD   = 'h02,
    OP_LDI  = 'h03,
    OP_ADD  = 'h04,
    OP_ADDI = 'h05,
    OP_SUB  = 'h06,
    OP_SUBI = 'h07,
    OP_AND  = 'h08,
    OP_ANDI = 'h09,
    OP_OR   = 'h0A,
    OP_ORI  = 'h0B,
    OP_XOR  = 'h0C,
    OP_XORI = 'h0D,
    OP_JMP  = 'h0E,
    OP_BEQ  = 'h0F,
    OP_BNE  = 'h10,
    OP_BNEG = 'h11,
    OP_NOP  = 'h12
  } op_t;

  state_t             state;
  logic [NBITS_O-1:0] pc;
  logic [NBITS_D-1:0] acc;
  logic [NBITS_D-1:0] ir;

  logic [NBITS_O-1:0] pc_inc;
  op_t                ex_op;
  op_t                mem_op;
  logic [NBITS_O-1:0] ex_opd;
  logic [NBITS_D-1:0] ex_imm;

  logic [NBITS_D-1:0] ex_acc;
  logic [NBITS_O-1:0] ex_pc;
  logic               ex_mem;
  logic               ex_halt;
  logic               ex_ill;

  // Register-sourced outputs: PC, IR operand and ACC are already registers.
  assign bus.o_PmAddr = pc;
  assign bus.o_DmAddr = ir[NBITS_O-1:0];
  assign bus.o_InData = acc;

  assign pc_inc = pc + NBITS_O'(1);
  assign ex_op  = op_t'(bus.i_Instruction[NBITS_D-1 -: OPCODE]);
  assign mem_op = op_t'(ir[NBITS_D-1 -: OPCODE]);
  assign ex_opd = bus.i_Instruction[NBITS_O-1:0];
  assign ex_imm = {{(NBITS_D-NBITS_O){ex_opd[NBITS_O-1]}}, ex_opd};

  // Memory-operand and immediate variants share one operation table.
  function automatic logic [NBITS_D-1:0] alu(input op_t op,
                                             input logic [NBITS_D-1:0] a,
                                             input logic [NBITS_D-1:0] b);
    case (op)
      OP_ADD, OP_ADDI: alu = a + b;
      OP_SUB, OP_SUBI: alu = a - b;
      OP_AND, OP_ANDI: alu = a & b;
      OP_OR,  OP_ORI:  alu = a | b;
      OP_XOR, OP_XORI: alu = a ^ b;
      default:         alu = b;
    endcase
  endfunction

  // EXEC decodes straight from the program memory output; IR is only
  // needed afterwards to carry the opcode and operand through MEM.
  always_comb begin
    ex_acc  = acc;
    ex_pc   = pc_inc;
    ex_mem  = 1'b0;
    ex_halt = 1'b0;
    ex_ill  = 1'b0;
    case (ex_op)
      OP_HLT: begin
        ex_halt = 1'b1;
        ex_pc   = pc;
      end
      OP_STO, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
        ex_mem = 1'b1;
      OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI:
        ex_acc = alu(ex_op, acc, ex_imm);
      OP_JMP:  ex_pc = ex_opd;
      OP_BEQ:  if (acc == '0)        ex_pc = ex_opd;
      OP_BNE:  if (acc != '0)        ex_pc = ex_opd;
      OP_BNEG: if (acc[NBITS_D-1])   ex_pc = ex_opd;
      OP_NOP:  ;
      default: ex_ill = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state           <= FETCH;
      pc              <= '0;
      acc             <= '0;
      ir              <= '0;
      bus.o_Rd        <= 1'b0;
      bus.o_Wr        <= 1'b0;
      bus.o_Halted    <= 1'b0;
      bus.o_IllegalOp <= 1'b0;
    end else begin
      bus.o_IllegalOp <= 1'b0;
      case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          ir <= bus.i_Instruction;
          if (ex_halt) begin
            state        <= HALT;
            bus.o_Halted <= 1'b1;
          end else if (ex_mem) begin
            state <= MEM;
            if (ex_op == OP_STO) bus.o_Wr <= 1'b1;
            else                 bus.o_Rd <= 1'b1;
          end else begin
            state           <= FETCH;
            acc             <= ex_acc;
            pc              <= ex_pc;
            bus.o_IllegalOp <= ex_ill;
          end
        end
        MEM: begin
          if (bus.i_DmReady) begin
            bus.o_Rd <= 1'b0;
            bus.o_Wr <= 1'b0;
            if (mem_op != OP_STO) acc <= alu(mem_op, acc, bus.i_OutData);
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
